pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Pipeline controller for the 5-stage RV32I datapath (F/D/E/M/W).
- Carries main-decoder control bits from D to W with per-stage valid bits.
- Detects load-use hazards and stalls F/D. Resolves branch/jump in E and flushes D/E.
- Generates E-stage operand-forwarding selects. Keeps retire/stall/flush performance counters.

Parameters:
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (reset==0 resets)
RegWriteD  in  1  decoder register-write enable
ResultSrcD  in  2  decoder result select (00 ALU, 01 load, 10 PC+4)
MemWriteD  in  1  decoder store enable
JumpD  in  1  jal/jalr
BranchD  in  1  conditional branch
ALUControlD  in  4  ALU operation
ALUSrcD  in  1  ALU B-operand select
Rs1D  in  5  Instr_D[19:15]
Rs2D  in  5  Instr_D[24:20]
RdD  in  5  Instr_D[11:7]
ZeroE  in  1  ALU zero flag, E stage
StallF  out  1  hold PC register
StallD  out  1  hold F/D register
FlushD  out  1  clear F/D register
FlushE  out  1  clear D/E datapath register
PCSrcE  out  1  select PCTargetE
ForwardAE  out  2  SrcA select: 00 RD1E, 01 ResultW, 10 ALUResultM
ForwardBE  out  2  SrcB-pre-mux select, same encoding as ForwardAE
ALUControlE  out  4  E-stage ALU op
ALUSrcE  out  1  E-stage B select
MemWriteM  out  1  M-stage store enable (already gated by validM)
RegWriteW  out  1  W-stage write enable (already gated by validW)
ResultSrcW  out  2  W-stage result select
RdW  out  5  W-stage destination
InstRet  out  CNT_W  retired-instruction count
StallCnt  out  CNT_W  load-use stall cycles
FlushCnt  out  CNT_W  taken redirects

Behaviour:
- Reset (async, reset==0):
  - All stage registers and valid bits clear to 0; counters clear to 0.
  - All outputs read 0, including Forward* = 00 and PCSrcE = 0.
  - Asserting reset mid-operation discards all in-flight state immediately.
- validD (tracks the F/D register):
  - Next value = StallD ? validD : ~FlushD.
  - Therefore 0 in the first cycle after reset release and 1 thereafter.
- D->E register:
  - Captures D control bits, Rs1D/Rs2D/RdD and validD every cycle.
  - If FlushE: loads a bubble (all enables 0, valid 0).
  - The E stage never stalls.
- E->M and M->W registers: advance unconditionally every cycle.
- Enable gating: every write/store/branch/jump enable is ANDed with its stage valid bit.
- Load-use detection:
  - lwStall = validE & RegWriteE & (ResultSrcE==01) & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D).
  - Conservative: Rs2D is compared even for I-type instructions.
- Redirect: PCSrcE = validE & (JumpE | (BranchE & ZeroE)).
- Stall/flush outputs:
  - StallF = StallD = lwStall & ~PCSrcE.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
  - Redirect has priority over stall.
- Forwarding A (combinational from E/M/W regs):
  - 10 if RegWriteM & RdM!=0 & RdM==Rs1E;
  - else 01 if RegWriteW & RdW!=0 & RdW==Rs1E;
  - else 00.
  - M has priority over W.
- Forwarding B: identical rule using Rs2E.
- Load in M: never a forward source (lwStall guarantees it).
- Latency:
  - One stall bubble per load-use.
  - Two squashed slots per taken branch/jump.
  - Control arrives at W 3 cycles after leaving D.
- Counters:
  - InstRet += 1 when validW.
  - StallCnt += 1 when StallD.
  - FlushCnt += 1 when PCSrcE.
  - Each wraps modulo 2^CNT_W.

Decomposition:
- Package pipe_pkg:
  - ResultSrc encodings (RES_ALU=2'b00, RES_LOAD=2'b01, RES_PC4=2'b10).
  - Forward encodings (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10).
  - Packed structs ctrl_e_t, ctrl_m_t, ctrl_w_t for the per-stage control/valid/register-index bundles.
- Sub-module hazard_unit:
  - Purely combinational.
  - Computes lwStall, Stall*/Flush* and Forward* from stage fields.
- pipe_hazard_ctrl:
  - Owns the stage registers and counters.

Test Plan:
- Reset: drive 10 cycles of traffic, then reset=0 mid-cycle -> all outputs 0 asynchronously; after release, InstRet stays 0 for 4 cycles.
- RAW M-forward: add x5,x1,x2 then sub x6,x5,x3 back-to-back -> ForwardAE=10 during sub's E cycle; with one nop between -> ForwardAE=01.
- Priority: add x5; addi x5; add x6,x5,x5 -> ForwardAE=ForwardBE=10 (M wins over W).
- Load-use: lw x5,0(x1); add x6,x0,x5 -> StallF=StallD=FlushE=1 for exactly one cycle, then ForwardBE=01; StallCnt=1.
- Taken branch: beq with ZeroE=1 -> PCSrcE=FlushD=FlushE=1 for one cycle; two younger slots never raise RegWriteW/MemWriteM; FlushCnt=1; InstRet excludes them.
- x0 destination: lw x0 followed by use of x0, and add x0 followed by use of x0 -> no stall, Forward*=00.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings and per-stage control bundles for the 5-stage RV32I pipeline controller.
package pipe_pkg;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [3:0] alu_control;
    logic       alu_src;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ctrl_e_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic [4:0] rd;
  } ctrl_m_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] result_src;
    logic [4:0] rd;
  } ctrl_w_t;

  // M outranks W because it holds the younger write to the same register.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input ctrl_m_t m, input ctrl_w_t w);
    if (m.valid && m.reg_write && m.rd != 5'd0 && m.rd == rs) return FWD_M;
    if (w.valid && w.reg_write && w.rd != 5'd0 && w.rd == rs) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_unit.sv
// Combinational hazard logic: load-use stall, branch/jump redirect and E-stage forwarding selects.
module hazard_unit
  import pipe_pkg::*;
(
  input  ctrl_e_t    ce,
  input  ctrl_m_t    cm,
  input  ctrl_w_t    cw,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic       zero_e,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e,
  output logic       pc_src_e,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  logic lw_stall;

  // rs2 is compared even for I-type: a spurious stall is cheaper than decoding format here.
  assign lw_stall = ce.valid & ce.reg_write & (ce.result_src == RES_LOAD) & (ce.rd != 5'd0) &
                    ((ce.rd == rs1_d) | (ce.rd == rs2_d));

  assign pc_src_e = ce.valid & (ce.jump | (ce.branch & zero_e));

  // A redirect squashes the stalled instruction anyway, so it wins.
  assign stall_f  = lw_stall & ~pc_src_e;
  assign stall_d  = lw_stall & ~pc_src_e;
  assign flush_d  = pc_src_e;
  assign flush_e  = lw_stall | pc_src_e;

  assign fwd_a = fwd_sel(ce.rs1, cm, cw);
  assign fwd_b = fwd_sel(ce.rs2, cm, cw);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// D->W control pipeline with valid tracking, hazard unit hookup and performance counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWriteD,
  input  logic [1:0]       ResultSrcD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic [3:0]       ALUControlD,
  input  logic             ALUSrcD,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             ZeroE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             PCSrcE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [3:0]       ALUControlE,
  output logic             ALUSrcE,
  output logic             MemWriteM,
  output logic             RegWriteW,
  output logic [1:0]       ResultSrcW,
  output logic [4:0]       RdW,
  output logic [CNT_W-1:0] InstRet,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  logic    valid_d;
  ctrl_e_t ce;
  ctrl_m_t cm;
  ctrl_w_t cw;

  hazard_unit u_haz (
    .ce       (ce),
    .cm       (cm),
    .cw       (cw),
    .rs1_d    (Rs1D),
    .rs2_d    (Rs2D),
    .zero_e   (ZeroE),
    .stall_f  (StallF),
    .stall_d  (StallD),
    .flush_d  (FlushD),
    .flush_e  (FlushE),
    .pc_src_e (PCSrcE),
    .fwd_a    (ForwardAE),
    .fwd_b    (ForwardBE)
  );

  // Enables are gated with valid at capture so squashed slots carry no side effects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_d <= 1'b0;
      ce      <= '0;
      cm      <= '0;
      cw      <= '0;
    end else begin
      valid_d <= StallD ? valid_d : ~FlushD;
      if (FlushE) ce <= '0;
      else ce <= '{valid: valid_d, reg_write: RegWriteD & valid_d, result_src: ResultSrcD,
                   mem_write: MemWriteD & valid_d, jump: JumpD & valid_d,
                   branch: BranchD & valid_d, alu_control: ALUControlD, alu_src: ALUSrcD,
                   rs1: Rs1D, rs2: Rs2D, rd: RdD};
      cm <= '{valid: ce.valid, reg_write: ce.reg_write, result_src: ce.result_src,
              mem_write: ce.mem_write, rd: ce.rd};
      cw <= '{valid: cm.valid, reg_write: cm.reg_write, result_src: cm.result_src, rd: cm.rd};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      InstRet  <= '0;
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      InstRet  <= InstRet  + CNT_W'(cw.valid);
      StallCnt <= StallCnt + CNT_W'(StallD);
      FlushCnt <= FlushCnt + CNT_W'(PCSrcE);
    end
  end

  assign ALUControlE = ce.alu_control;
  assign ALUSrcE     = ce.alu_src;
  assign MemWriteM   = cm.valid & cm.mem_write;
  assign RegWriteW   = cw.valid & cw.reg_write;
  assign ResultSrcW  = cw.result_src;
  assign RdW         = cw.rd;

endmodule
